// File: rtl/aes_inv_key_sched.sv
// AES inverse key scheduler: expands forward to the last round key, then emits NR..0.
// Define AES_KS_EQINV_EN to emit InvMixColumns'd middle keys for the equivalent inverse cipher.
module aes_inv_key_sched #(
  parameter int NK = 6,
  parameter int NR = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [0:32*NK-1]  key,
  input  logic              key_valid,
  output logic              key_ready,
  output logic [0:127]      rk,
  output logic [3:0]        rk_round,
  output logic              rk_last,
  output logic              rk_valid,
  input  logic              rk_ready
);

  localparam int W = 4 * (NR + 1);
  localparam logic [5:0] JEND = 6'(W - NK);
  localparam logic [5:0] NKW = 6'(NK);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  state_t      state, state_nx;
  logic [31:0] win [NK];
  logic [31:0] win_nx [NK];
  logic [5:0]  j, j_nx;
  logic [3:0]  r, r_nx;
  logic        vld, vld_nx;
  logic [31:0] fwd_w, bwd_w;
  logic [5:0]  off;
  logic [0:127] rk_raw;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [5:0] n);
    logic [7:0] v;
    unique case (n)
      6'd1:    v = 8'h01;
      6'd2:    v = 8'h02;
      6'd3:    v = 8'h04;
      6'd4:    v = 8'h08;
      6'd5:    v = 8'h10;
      6'd6:    v = 8'h20;
      6'd7:    v = 8'h40;
      6'd8:    v = 8'h80;
      6'd9:    v = 8'h1b;
      6'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] temp(input logic [31:0] x, input logic [5:0] i);
    logic [5:0] m;
    m = i % NKW;
    if (m == 6'd0)
      return subword({x[23:0], x[31:24]}) ^ {rcon(i / NKW), 24'h0};
    else if (NK > 6 && m == 6'd4)
      return subword(x);
    else
      return x;
  endfunction

  function automatic logic [5:0] tgt(input logic [3:0] rr);
    logic [5:0] t;
    t = {rr, 2'b00};
    return (t > JEND) ? JEND : t;
  endfunction

`ifdef AES_KS_EQINV_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return (c[0] ? b : 8'h0) ^ (c[1] ? b2 : 8'h0) ^
           (c[2] ? b4 : 8'h0) ^ (c[3] ? b8 : 8'h0);
  endfunction

  function automatic logic [31:0] invmix(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {
      gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
      gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
      gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
      gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)
    };
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      j     <= '0;
      r     <= '0;
      vld   <= 1'b0;
      for (int k = 0; k < NK; k++) win[k] <= '0;
    end else begin
      state <= state_nx;
      j     <= j_nx;
      r     <= r_nx;
      vld   <= vld_nx;
      for (int k = 0; k < NK; k++) win[k] <= win_nx[k];
    end
  end

  // window holds w[j..j+NK-1]; forward appends at the top, backward at the bottom
  always_comb begin
    state_nx = state;
    win_nx   = win;
    j_nx     = j;
    r_nx     = r;
    vld_nx   = vld;
    fwd_w    = win[0] ^ temp(win[NK-1], j + NKW);
    bwd_w    = win[NK-1] ^ temp(win[NK-2], j + NKW - 6'd1);
    unique case (state)
      IDLE: begin
        if (key_valid) begin
          for (int k = 0; k < NK; k++) win_nx[k] = key[32*k +: 32];
          j_nx     = '0;
          state_nx = FWD;
        end
      end
      FWD: begin
        for (int k = 0; k < NK - 1; k++) win_nx[k] = win[k+1];
        win_nx[NK-1] = fwd_w;
        j_nx = j + 6'd1;
        if (j + 6'd1 == JEND) begin
          r_nx     = 4'(NR);
          vld_nx   = 1'b1;
          state_nx = REV;
        end
      end
      REV: begin
        if (vld) begin
          if (rk_ready) begin
            vld_nx = 1'b0;
            if (r == 4'd0) state_nx = IDLE;
            else r_nx = r - 4'd1;
          end
        end else if (j != tgt(r)) begin
          for (int k = 1; k < NK; k++) win_nx[k] = win[k-1];
          win_nx[0] = bwd_w;
          j_nx = j - 6'd1;
          if (j - 6'd1 == tgt(r)) vld_nx = 1'b1;
        end else begin
          vld_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    off    = {r, 2'b00} - j;
    rk_raw = '0;
    for (int q = 0; q < 4; q++)
      for (int k = 0; k < NK; k++)
        if (6'(k) == off + 6'(q)) rk_raw[32*q +: 32] = win[k];
  end

`ifdef AES_KS_EQINV_EN
  logic [0:127] rk_mix;

  always_comb begin
    rk_mix = rk_raw;
    if (r != 4'd0 && r != 4'(NR))
      for (int q = 0; q < 4; q++)
        rk_mix[32*q +: 32] = invmix(rk_raw[32*q +: 32]);
  end

  assign rk = vld ? rk_mix : '0;
`else
  assign rk = vld ? rk_raw : '0;
`endif

  assign key_ready = (state == IDLE);
  assign rk_valid  = vld;
  assign rk_round  = r;
  assign rk_last   = vld && (r == 4'd0);

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched: AES-128/192/256 schedules,
// backpressure hold, key ignore outside IDLE and mid-expansion reset.
module tb_aes_inv_key_sched;

  localparam logic [0:255] K128 = {
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] K192 = {
    192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [0:255] K256 = {
    128'h603deb1015ca71be2b73aef0857d7781,
    128'h1f352c073b6108d72d9810a30914dff4};

  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R128_9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] R128_5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] R128_2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R192_11 = 128'hca4005388fcc5006282d166abc3ce7b5;
  localparam logic [127:0] R192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [0:127] key4;
  logic [0:191] key6;
  logic [0:255] key8;
  logic         kv  [3];
  logic         kr  [3];
  logic [0:127] rk  [3];
  logic [3:0]   rnd [3];
  logic         rl  [3];
  logic         rv  [3];
  logic         rr  [3];

  int           n_chk = 0;
  int           n_fail = 0;
  logic [0:127] got_rk   [16];
  logic [3:0]   got_rnd  [16];
  logic         got_last [16];
  int           got_t    [16];
  int           n_hs;
  int           lat;

  always #5 clk = ~clk;

  aes_inv_key_sched #(.NK(4), .NR(10)) u4 (
    .clk(clk), .rst_n(rst_n), .key(key4), .key_valid(kv[0]),
    .key_ready(kr[0]), .rk(rk[0]), .rk_round(rnd[0]),
    .rk_last(rl[0]), .rk_valid(rv[0]), .rk_ready(rr[0]));

  aes_inv_key_sched #(.NK(6), .NR(12)) u6 (
    .clk(clk), .rst_n(rst_n), .key(key6), .key_valid(kv[1]),
    .key_ready(kr[1]), .rk(rk[1]), .rk_round(rnd[1]),
    .rk_last(rl[1]), .rk_valid(rv[1]), .rk_ready(rr[1]));

  aes_inv_key_sched #(.NK(8), .NR(14)) u8 (
    .clk(clk), .rst_n(rst_n), .key(key8), .key_valid(kv[2]),
    .key_ready(kr[2]), .rk(rk[2]), .rk_round(rnd[2]),
    .rk_last(rl[2]), .rk_valid(rv[2]), .rk_ready(rr[2]));

`ifdef AES_KS_EQINV_EN
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mid(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0] c [4];
    for (int q = 0; q < 4; q++) begin
      for (int b = 0; b < 4; b++) c[b] = x[127 - 32*q - 8*b -: 8];
      for (int b = 0; b < 4; b++)
        y[127 - 32*q - 8*b -: 8] =
          gmul(c[b], 8'h0e) ^ gmul(c[(b+1)%4], 8'h0b) ^
          gmul(c[(b+2)%4], 8'h0d) ^ gmul(c[(b+3)%4], 8'h09);
    end
    return y;
  endfunction
`else
  function automatic logic [127:0] mid(input logic [127:0] x);
    return x;
  endfunction
`endif

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int s, input logic [0:255] k);
    key4 = k[0:127];
    key6 = k[0:191];
    key8 = k;
    kv[s] = 1'b1;
    tick();
    kv[s] = 1'b0;
    lat = 0;
    while (!rv[s] && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic collect(input int s);
    int t;
    logic done;
    n_hs = 0;
    t = 0;
    done = 1'b0;
    while (!done && t < 400) begin
      if (rv[s] && rr[s] && n_hs < 16) begin
        got_rk[n_hs]   = rk[s];
        got_rnd[n_hs]  = rnd[s];
        got_last[n_hs] = rl[s];
        got_t[n_hs]    = t;
        n_hs++;
        done = rl[s];
      end
      tick();
      t++;
    end
  endtask

  initial begin
    int t;
    logic [0:127] hold;
    for (int i = 0; i < 3; i++) begin
      kv[i] = 1'b0;
      rr[i] = 1'b1;
    end
    key4 = '0;
    key6 = '0;
    key8 = '0;
    repeat (3) tick();
    chk("rst_krdy", kr[0], 1);
    chk("rst_vld", rv[0], 0);
    chk("rst_rk", rk[0], 0);
    chk("rst_rnd_last", {rnd[0], rl[0]}, 0);
    rst_n = 1'b1;
    tick();

    // AES-128 full reverse schedule
    start(0, K128);
    chk("a128_lat", lat, 40);
    collect(0);
    chk("a128_nhs", n_hs, 11);
    for (int i = 0; i < 11; i++) chk("a128_rnd", got_rnd[i], 10 - i);
    chk("a128_r10", got_rk[0], R128_10);
    chk("a128_r9", got_rk[1], mid(R128_9));
    chk("a128_r5", got_rk[5], mid(R128_5));
    chk("a128_r2", got_rk[8], mid(R128_2));
    chk("a128_r1", got_rk[9], mid(R128_1));
    chk("a128_r0", got_rk[10], K128[0:127]);
    chk("a128_last", {got_last[9], got_last[10]}, 2'b01);
    chk("a128_gap", got_t[1] - got_t[0], 5);
    chk("a128_krdy", kr[0], 1);

    // AES-192
    start(1, K192);
    chk("a192_lat", lat, 46);
    collect(1);
    chk("a192_nhs", n_hs, 13);
    chk("a192_r12", got_rk[0], R192_12);
    chk("a192_rnd12", got_rnd[0], 12);
    chk("a192_r11", got_rk[1], mid(R192_11));
    chk("a192_gap", got_t[1] - got_t[0], 3);
    chk("a192_r1", got_rk[11], mid(R192_1));
    chk("a192_r0", got_rk[12], K192[0:127]);
    chk("a192_last", {got_rnd[12], got_last[12]}, {4'd0, 1'b1});

    // AES-256
    start(2, K256);
    chk("a256_lat", lat, 52);
    collect(2);
    chk("a256_nhs", n_hs, 15);
    chk("a256_r14", got_rk[0], R256_14);
    chk("a256_rnd13", got_rnd[1], 13);
    chk("a256_gap", got_t[1] - got_t[0], 2);
    chk("a256_r1", got_rk[13], mid(K256[128:255]));
    chk("a256_r0", got_rk[14], K256[0:127]);
    chk("a256_last", got_last[14], 1);

    // backpressure at round 5 with a stray key pulse
    start(0, K128);
    t = 0;
    while (!(rv[0] && rnd[0] == 4'd5) && t < 200) begin
      tick();
      t++;
    end
    rr[0] = 1'b0;
    hold = rk[0];
    chk("bp_at5", {rv[0], rnd[0]}, {1'b1, 4'd5});
    chk("bp_val5", hold, mid(R128_5));
    key4 = '0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) kv[0] = 1'b1;
      tick();
      kv[0] = 1'b0;
      chk("bp_rk", rk[0], hold);
      chk("bp_ctl", {rv[0], rnd[0], rl[0], kr[0]}, {1'b1, 4'd5, 1'b0, 1'b0});
    end
    rr[0] = 1'b1;
    collect(0);
    chk("bp_nhs", n_hs, 6);
    chk("bp_first", got_rk[0], mid(R128_5));
    chk("bp_r0", got_rk[5], K128[0:127]);
    chk("bp_last", got_last[5], 1);

    // reset during forward expansion
    key4 = K128[0:127];
    kv[0] = 1'b1;
    tick();
    kv[0] = 1'b0;
    repeat (10) tick();
    chk("mid_krdy", kr[0], 0);
    rst_n = 1'b0;
    tick();
    chk("mr_krdy", kr[0], 1);
    chk("mr_out", {rv[0], rl[0], rnd[0]}, 0);
    chk("mr_rk", rk[0], 0);
    rst_n = 1'b1;
    start(0, K128);
    chk("mr_lat", lat, 40);
    collect(0);
    chk("mr_nhs", n_hs, 11);
    chk("mr_r10", got_rk[0], R128_10);
    chk("mr_r1", got_rk[9], mid(R128_1));
    chk("mr_r0", got_rk[10], K128[0:127]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
